clk_switch_ctrl: RTL

- Control-side partner of the glitch-free clock mux: generates the mux `sel`, running on one free-running reference clock.
- Accepts switch requests over a valid/ready handshake and checks that the target source clock is alive before changing `sel`.
- Holds a settle interval after each change so the mux handover completes, then reports done or error.
- Optionally fails over automatically when the active source stops.

---
 rtl/clk_switch_ctrl_pkg.sv | 20 ++
 rtl/clk_switch_ctrl_activity_mon.sv | 49 ++++
 rtl/clk_switch_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/clk_switch_ctrl_pkg.sv
// Shared definitions for the clock-switch controller: FSM encodings,
// source indices and a counter-width helper.
package clk_switch_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_CHECK  = 2'd1;
    localparam state_t ST_SWITCH = 2'd2;
    localparam state_t ST_SETTLE = 2'd3;

    localparam int SRC_CLK0 = 0;
    localparam int SRC_CLK1 = 1;

    // Counter width for a counter spanning 0..n-1; never narrower than 1 bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_switch_ctrl_activity_mon.sv
// Activity monitor for one source: synchronize the divide-by-2 toggle,
// detect its edges and count them (saturating) over each detection window.
module clk_activity_mon #(
    parameter int MIN_EDGES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic tog,
    input  logic win_end,
    output logic alive,
    output logic alive_new
);

    localparam int CW = $clog2(MIN_EDGES + 1);

    logic          s1, s2, s3;
    logic          upd;
    logic          edg;
    logic [CW-1:0] cnt;

    assign edg       = s2 ^ s3;
    assign alive_new = (cnt >= CW'(MIN_EDGES));

    // Sync/edge pipeline, window-end delay, saturating edge count and status.
    // The count restarts in the update cycle but still keeps that cycle's edge,
    // so every window spans exactly the window-counter period.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            s3    <= 1'b0;
            upd   <= 1'b0;
            cnt   <= '0;
            alive <= 1'b0;
        end else begin
            s1  <= tog;
            s2  <= s1;
            s3  <= s2;
            upd <= win_end;
            if (upd) begin
                alive <= alive_new;
                cnt   <= CW'(edg);
            end else if (edg && (cnt != CW'(MIN_EDGES))) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_switch_ctrl.sv
// Control side of the glitch-free clock mux: validates switch requests
// against source activity, drives sel, waits out the mux handover and
// fails over automatically when the active source dies.
module clk_switch_ctrl
    import clk_switch_ctrl_pkg::*;
#(
    parameter int DET_WIN     = 64,
    parameter int MIN_EDGES   = 4,
    parameter int SETTLE      = 16,
    parameter int FAILOVER_EN = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic req_valid,
    input  logic req_sel,
    output logic req_ready,
    input  logic clk0_tog,
    input  logic clk1_tog,
    output logic sel,
    output logic busy,
    output logic done,
    output logic err,
    output logic failover,
    output logic clk0_alive,
    output logic clk1_alive
);

    localparam int WW = cnt_w(DET_WIN);
    localparam int SW = cnt_w(SETTLE);

    logic [WW-1:0] win_cnt;
    logic          win_end;
    logic          alive_upd;
    logic [1:0]    alive_new;
    state_t        state;
    logic          tgt;
    logic [SW-1:0] settle_cnt;
    logic          fo_cond;
    logic          req_fire;

    assign win_end   = (win_cnt == WW'(DET_WIN - 1));
    assign fo_cond   = (FAILOVER_EN != 0) && (state == ST_IDLE) && alive_upd &&
                       !alive_new[sel] && alive_new[~sel];
    assign req_ready = (state == ST_IDLE) && !fo_cond && !reset;
    assign req_fire  = req_valid && req_ready;
    assign busy      = (state != ST_IDLE);

    clk_activity_mon #(.MIN_EDGES(MIN_EDGES)) u_mon0 (
        .clk       (clk),
        .reset     (reset),
        .tog       (clk0_tog),
        .win_end   (win_end),
        .alive     (clk0_alive),
        .alive_new (alive_new[SRC_CLK0])
    );

    clk_activity_mon #(.MIN_EDGES(MIN_EDGES)) u_mon1 (
        .clk       (clk),
        .reset     (reset),
        .tog       (clk1_tog),
        .win_end   (win_end),
        .alive     (clk1_alive),
        .alive_new (alive_new[SRC_CLK1])
    );

    // Shared detection window; alive_upd marks the cycle the monitors reload.
    always_ff @(posedge clk) begin
        if (reset) begin
            win_cnt   <= '0;
            alive_upd <= 1'b0;
        end else begin
            win_cnt   <= win_end ? '0 : win_cnt + 1'b1;
            alive_upd <= win_end;
        end
    end

    // Switch FSM; done/err/failover are single-cycle pulses from this block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            sel        <= 1'b0;
            tgt        <= 1'b0;
            settle_cnt <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            failover   <= 1'b0;
        end else begin
            done     <= 1'b0;
            err      <= 1'b0;
            failover <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // Failover has priority; req_ready is already low then.
                    if (fo_cond) begin
                        tgt      <= ~sel;
                        failover <= 1'b1;
                        state    <= ST_SWITCH;
                    end else if (req_fire) begin
                        if (req_sel == sel) begin
                            done <= 1'b1;
                        end else begin
                            tgt   <= req_sel;
                            state <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    // Decide only on a full window that finished after the request.
                    if (alive_upd) begin
                        if (alive_new[tgt]) begin
                            state <= ST_SWITCH;
                        end else begin
                            err   <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_SWITCH: begin
                    sel        <= tgt;
                    settle_cnt <= SW'(SETTLE - 1);
                    state      <= ST_SETTLE;
                end
                default: begin
                    if (settle_cnt == '0) begin
                        done  <= 1'b1;
                        state <= ST_IDLE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
